// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst write arbiter sharing one FIFO write port among NUM_REQ valid/ready/last producers.
// Define FIFO_WR_ARB_STATS_EN to add the 16-bit saturating stall_cycles counter output.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [NUM_REQ-1:0]                         req_valid,
    input  logic [NUM_REQ-1:0]                         req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]              req_data,
    output logic [NUM_REQ-1:0]                         req_ready,
    input  logic                                       fifo_full,
    output logic                                       fifo_wr_en,
    output logic [DATA_WIDTH-1:0]                      fifo_wr_data,
    output logic [((NUM_REQ > 2) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
    output logic                                       busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [15:0]                                stall_cycles
`endif
);

    localparam int GW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    if (NUM_REQ < 2) begin : g_bad_num_req
        $fatal(1, "fifo_wr_arbiter: NUM_REQ must be >= 2");
    end
    if (MAX_BURST < 1) begin : g_bad_max_burst
        $fatal(1, "fifo_wr_arbiter: MAX_BURST must be >= 1");
    end

    state_t                r_state;
    state_t                w_state_nxt;
    logic [GW-1:0]         r_grant_id;
    logic [GW-1:0]         w_grant_nxt;
    logic [CW-1:0]         r_burst_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  w_offer;
    logic                  w_beat;
    logic [DATA_WIDTH-1:0] w_data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign w_data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // First valid requester strictly after ptr, wrapping; the reverse scan leaves the nearest one last.
    function automatic logic [GW-1:0] f_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [GW-1:0]      ptr);
        int idx;
        f_pick = ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (valid[GW'(idx)]) f_pick = GW'(idx);
        end
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_grant_id  <= GW'(NUM_REQ - 1);
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant_id  <= w_grant_nxt;
            r_burst_cnt <= w_cnt_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_id;
        w_cnt_nxt   = r_burst_cnt;
        case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_state_nxt = LOCKED;
                    w_grant_nxt = f_pick(req_valid, r_grant_id);
                    w_cnt_nxt   = '0;
                end
            end
            LOCKED: begin
                if (w_beat) begin
                    if (req_last[r_grant_id] || (r_burst_cnt == CW'(MAX_BURST - 1))) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_burst_cnt + CW'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        w_offer    = 1'b0;
        w_beat     = 1'b0;
        busy       = (r_state == LOCKED);
        if (r_state == LOCKED) begin
            req_ready[r_grant_id] = !fifo_full;
            w_offer               = req_valid[r_grant_id];
            w_beat                = w_offer && !fifo_full;
        end
        fifo_wr_en   = w_beat;
        fifo_wr_data = w_data_arr[r_grant_id];
        grant_id     = r_grant_id;
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (w_offer && fifo_full && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

`ifndef SYNTHESIS
    // A beat offered while stalled must stay valid with unchanged data/last until accepted.
    logic                  r_pend;
    logic [DATA_WIDTH-1:0] r_pend_data;
    logic                  r_pend_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend      <= 1'b0;
            r_pend_data <= '0;
            r_pend_last <= 1'b0;
        end else if (w_offer && !w_beat) begin
            r_pend <= 1'b1;
            if (!r_pend) begin
                r_pend_data <= w_data_arr[r_grant_id];
                r_pend_last <= req_last[r_grant_id];
            end
        end else begin
            r_pend <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst_n && r_pend && (r_state == LOCKED)) begin
            assert (req_valid[r_grant_id])
                else $fatal(1, "fifo_wr_arbiter: req_valid dropped while stalled");
            assert ((w_data_arr[r_grant_id] == r_pend_data) && (req_last[r_grant_id] == r_pend_last))
                else $fatal(1, "fifo_wr_arbiter: req_data/req_last changed while stalled");
        end
    end

    a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
    a_no_overflow:   assert property (@(posedge clk) disable iff (!rst_n) fifo_wr_en |-> !fifo_full);
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a default instance (MAX_BURST=4) and a MAX_BURST=1 instance.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [3:0]  req_valid, req_last, req_ready;
    logic [31:0] req_data;
    logic        fifo_full, fifo_wr_en, busy;
    logic [7:0]  fifo_wr_data;
    logic [1:0]  grant_id;

    logic [3:0]  b_req_valid, b_req_last, b_req_ready;
    logic [31:0] b_req_data;
    logic        b_fifo_full, b_fifo_wr_en, b_busy;
    logic [7:0]  b_fifo_wr_data;
    logic [1:0]  b_grant_id;

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] stall_cycles, b_stall_cycles;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data), .grant_id(grant_id), .busy(busy)
`ifdef FIFO_WR_ARB_STATS_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_last(b_req_last), .req_data(b_req_data),
        .req_ready(b_req_ready), .fifo_full(b_fifo_full), .fifo_wr_en(b_fifo_wr_en),
        .fifo_wr_data(b_fifo_wr_data), .grant_id(b_grant_id), .busy(b_busy)
`ifdef FIFO_WR_ARB_STATS_EN
        , .stall_cycles(b_stall_cycles)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic e_busy, input logic [1:0] e_gid,
                       input logic [3:0] e_ready, input logic e_wr);
        check({tag, ".busy"},     32'(busy),       32'(e_busy));
        check({tag, ".grant_id"}, 32'(grant_id),   32'(e_gid));
        check({tag, ".ready"},    32'(req_ready),  32'(e_ready));
        check({tag, ".wr_en"},    32'(fifo_wr_en), 32'(e_wr));
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = '0; req_last   = '0; req_data   = '0; fifo_full   = 1'b0;
        b_req_valid = '0; b_req_last = '0; b_req_data = '0; b_fifo_full = 1'b0;
        tick(); tick(); settle();
        chk("reset", 1'b0, 2'd3, 4'b0000, 1'b0);
        check("reset.b_grant_id", 32'(b_grant_id), 32'd3);
        tick();
        rst_n = 1'b1;

        // Single requester, two-beat packet ending on last.
        req_valid = 4'b0001; req_data = 32'h0000_00A0;
        settle();
        chk("s1.idle", 1'b0, 2'd3, 4'b0000, 1'b0);
        tick(); settle();
        chk("s1.beat0", 1'b1, 2'd0, 4'b0001, 1'b1);
        check("s1.data0", 32'(fifo_wr_data), 32'hA0);
        tick();
        req_data = 32'h0000_00A1; req_last = 4'b0001;
        settle();
        chk("s1.beat1", 1'b1, 2'd0, 4'b0001, 1'b1);
        check("s1.data1", 32'(fifo_wr_data), 32'hA1);
        tick();
        req_valid = '0; req_last = '0;
        settle();
        chk("s1.release", 1'b0, 2'd0, 4'b0000, 1'b0);

        // Fresh pointer, all four streaming: 0,1,2,3,0 each 4 beats, one IDLE cycle apart.
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_valid = 4'b1111; req_data = 32'hB3B2_B1B0;
        for (int b = 0; b < 5; b++) begin
            settle();
            chk($sformatf("s2.idle%0d", b), 1'b0, 2'((b + 3) % 4), 4'b0000, 1'b0);
            for (int k = 0; k < 4; k++) begin
                tick(); settle();
                chk($sformatf("s2.b%0d.k%0d", b, k), 1'b1, 2'(b % 4), 4'(1 << (b % 4)), 1'b1);
                check($sformatf("s2.b%0d.k%0d.data", b, k), 32'(fifo_wr_data), 32'hB0 + 32'(b % 4));
            end
            tick();
        end
        req_valid = '0;
        settle();
        chk("s2.end", 1'b0, 2'd0, 4'b0000, 1'b0);

        // Requester 2 stalled by fifo_full for 3 cycles after one beat.
        tick();
        req_valid = 4'b0100; req_data = 32'h00C2_0000;
        settle();
        tick(); settle();
        chk("s3.beat0", 1'b1, 2'd2, 4'b0100, 1'b1);
        tick();
        fifo_full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            settle();
            chk($sformatf("s3.stall%0d", s), 1'b1, 2'd2, 4'b0000, 1'b0);
            tick();
        end
        fifo_full = 1'b0;
        for (int k = 1; k < 4; k++) begin
            settle();
            chk($sformatf("s3.beat%0d", k), 1'b1, 2'd2, 4'b0100, 1'b1);
            check($sformatf("s3.data%0d", k), 32'(fifo_wr_data), 32'hC2);
            tick();
        end
        req_valid = '0;
        settle();
        chk("s3.release", 1'b0, 2'd2, 4'b0000, 1'b0);
`ifdef FIFO_WR_ARB_STATS_EN
        check("s3.stall_cycles", 32'(stall_cycles), 32'd3);
`endif

        // Requester 1 bubbles for 2 cycles while 3 waits; 3 is served only after 1 releases.
        tick();
        req_valid = 4'b0010; req_data = 32'h0000_D100;
        settle();
        tick(); settle();
        chk("s4.beat0", 1'b1, 2'd1, 4'b0010, 1'b1);
        tick();
        req_valid = 4'b1000;
        settle();
        chk("s4.bubble0", 1'b1, 2'd1, 4'b0010, 1'b0);
        tick(); settle();
        chk("s4.bubble1", 1'b1, 2'd1, 4'b0010, 1'b0);
        tick();
        req_valid = 4'b1010; req_last = 4'b0010;
        settle();
        chk("s4.last", 1'b1, 2'd1, 4'b0010, 1'b1);
        check("s4.data", 32'(fifo_wr_data), 32'hD1);
        tick();
        req_valid = 4'b1000; req_last = 4'b1000;
        settle();
        chk("s4.idle", 1'b0, 2'd1, 4'b0000, 1'b0);
        tick(); settle();
        chk("s4.grant3", 1'b1, 2'd3, 4'b1000, 1'b1);
        tick();
        req_valid = '0; req_last = '0;
        settle();
        chk("s4.release", 1'b0, 2'd3, 4'b0000, 1'b0);

        // Asynchronous reset during beat 3 of a burst, then 0 wins over 1.
        tick();
        req_valid = 4'b0001; req_data = 32'h0000_00E0;
        settle();
        tick(); settle();
        chk("s5.beat0", 1'b1, 2'd0, 4'b0001, 1'b1);
        tick(); settle();
        tick(); settle();
        chk("s5.beat2", 1'b1, 2'd0, 4'b0001, 1'b1);
        rst_n = 1'b0; req_valid = 4'b0011;
        #1;
        chk("s5.async_rst", 1'b0, 2'd3, 4'b0000, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        settle();
        chk("s5.idle", 1'b0, 2'd3, 4'b0000, 1'b0);
        tick();
        req_last = 4'b0011;
        settle();
        chk("s5.grant0", 1'b1, 2'd0, 4'b0001, 1'b1);
        tick(); settle();
        chk("s5.idle2", 1'b0, 2'd0, 4'b0000, 1'b0);
        tick(); settle();
        chk("s5.grant1", 1'b1, 2'd1, 4'b0010, 1'b1);
        tick();
        req_valid = '0; req_last = '0;
        settle();
        chk("s5.release", 1'b0, 2'd1, 4'b0000, 1'b0);

        // MAX_BURST=1: requesters 1 and 2 alternate, one beat per grant.
        tick();
        b_req_valid = 4'b0110; b_req_data = 32'h0062_5100;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("s6.idle%0d.busy", i),  32'(b_busy),       32'd0);
            check($sformatf("s6.idle%0d.wr_en", i), 32'(b_fifo_wr_en), 32'd0);
            tick(); settle();
            check($sformatf("s6.g%0d.busy", i),  32'(b_busy),         32'd1);
            check($sformatf("s6.g%0d.grant", i), 32'(b_grant_id),     (i % 2 == 0) ? 32'd1 : 32'd2);
            check($sformatf("s6.g%0d.wr_en", i), 32'(b_fifo_wr_en),   32'd1);
            check($sformatf("s6.g%0d.data", i),  32'(b_fifo_wr_data), (i % 2 == 0) ? 32'h51 : 32'h62);
            tick();
        end
        b_req_valid = '0;
        settle();
        check("s6.end.busy", 32'(b_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
